// File: rtl/onetoseven_deframer_pkg.sv
// Shared types and helpers for the 1-to-7 serial deframer.
// Collects a serial bit stream into a 7-slot parallel register.
package deframe_pkg;

    localparam int SLOTS_DEF = 7;
    localparam int SEL_W_DEF = 3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Out-of-range selects fall back to slot 0, matching the transmit-side mux default.
    function automatic int sel_clamp(input int sel, input int slots);
        int res;
        if (sel >= slots) begin
            res = 0;
        end else begin
            res = sel;
        end
        return res;
    endfunction

endpackage

// File: rtl/onetoseven_deframer_if.sv
// Serial-in / parallel-out bus of the deframer.
// The master drives the stimulus side; the deframer is the slave.
interface onetoseven_deframer_if #(
    parameter int SLOTS = deframe_pkg::SLOTS_DEF,
    parameter int SEL_W = deframe_pkg::SEL_W_DEF
);
    logic             serial_in;
    logic             in_valid;
    logic             mode;
    logic             start;
    logic             manual_we;
    logic [SEL_W-1:0] sel;
    logic [SLOTS-1:0] q;
    logic [SEL_W-1:0] slot;
    logic             busy;
    logic             frame_done;

    modport master (
        output serial_in, in_valid, mode, start, manual_we, sel,
        input  q, slot, busy, frame_done
    );

    modport slave (
        input  serial_in, in_valid, mode, start, manual_we, sel,
        output q, slot, busy, frame_done
    );
endinterface

// File: rtl/onetoseven_deframer_slot_counter.sv
// Slot index counter for auto-mode collection.
// Clear has priority over enable; wraps to zero after the last slot.
module slot_counter #(
    parameter int SLOTS = deframe_pkg::SLOTS_DEF,
    parameter int SEL_W = deframe_pkg::SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             term
);
    logic [SEL_W-1:0] cnt_r;
    logic             term_s;

    assign term_s = (cnt_r == SEL_W'(SLOTS - 1));
    assign cnt    = cnt_r;
    assign term   = term_s;

    // Counter register: clear, advance, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {SEL_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {SEL_W{1'b0}};
        end else if (en) begin
            cnt_r <= term_s ? {SEL_W{1'b0}} : cnt_r + SEL_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/onetoseven_deframer.sv
// 1-to-7 deframer: manual single-slot writes or auto collection of a full frame
// into a shadow register that is committed to q in one edge.
module onetoseven_deframer
    import deframe_pkg::*;
#(
    parameter int SLOTS = SLOTS_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    onetoseven_deframer_if.slave  bus
);
    state_t           state_r;
    state_t           state_next_s;
    logic [SLOTS-1:0] shadow_r;
    logic [SLOTS-1:0] q_r;
    logic [SLOTS-1:0] commit_val_s;
    logic             frame_done_r;
    logic             busy_r;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             cnt_term_s;
    logic [SEL_W-1:0] slot_s;
    logic [SEL_W-1:0] sel_idx_s;
    logic             shadow_clr_s;
    logic             shadow_we_s;
    logic             commit_s;
    logic             man_we_s;

    slot_counter #(
        .SLOTS (SLOTS),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (resetn),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .cnt   (slot_s),
        .term  (cnt_term_s)
    );

    assign sel_idx_s      = SEL_W'(sel_clamp(int'(bus.sel), SLOTS));
    assign bus.q          = q_r;
    assign bus.slot       = slot_s;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;

    // Next-state and control decode; abort (mode low) outranks restart and data.
    always_comb begin
        state_next_s  = state_r;
        cnt_clr_s     = 1'b0;
        cnt_en_s      = 1'b0;
        shadow_clr_s  = 1'b0;
        shadow_we_s   = 1'b0;
        commit_s      = 1'b0;
        man_we_s      = 1'b0;
        commit_val_s  = shadow_r;
        commit_val_s[SLOTS-1] = bus.serial_in;
        case (state_r)
            IDLE: begin
                if (bus.mode && bus.start) begin
                    state_next_s = COLLECT;
                    cnt_clr_s    = 1'b1;
                    shadow_clr_s = 1'b1;
                end else if (!bus.mode && bus.manual_we) begin
                    man_we_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (!bus.mode) begin
                    state_next_s = IDLE;
                    cnt_clr_s    = 1'b1;
                end else if (bus.start) begin
                    cnt_clr_s    = 1'b1;
                    shadow_clr_s = 1'b1;
                end else if (bus.in_valid) begin
                    if (cnt_term_s) begin
                        commit_s     = 1'b1;
                        cnt_clr_s    = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        shadow_we_s = 1'b1;
                        cnt_en_s    = 1'b1;
                    end
                end else begin
                    state_next_s = COLLECT;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_clr_s    = 1'b1;
            end
        endcase
    end

    // State register plus registered busy and frame_done status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s == COLLECT);
            frame_done_r <= commit_s;
        end
    end

    // Shadow register accumulates the frame without disturbing q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_r <= {SLOTS{1'b0}};
        end else if (shadow_clr_s) begin
            shadow_r <= {SLOTS{1'b0}};
        end else if (shadow_we_s) begin
            shadow_r[slot_s] <= bus.serial_in;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Output register: whole-frame commit or single-slot manual write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_r <= {SLOTS{1'b0}};
        end else if (commit_s) begin
            q_r <= commit_val_s;
        end else if (man_we_s) begin
            q_r[sel_idx_s] <= bus.serial_in;
        end else begin
            q_r <= q_r;
        end
    end
endmodule

// File: tb/tb_onetoseven_deframer.sv
// Directed self-checking bench for onetoseven_deframer.
module tb_onetoseven_deframer;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   fd_count;

    onetoseven_deframer_if #(.SLOTS(7), .SEL_W(3)) bus ();

    onetoseven_deframer #(.SLOTS(7), .SEL_W(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts frame_done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (resetn && bus.frame_done === 1'b1) fd_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.serial_in = 1'b0;
        bus.in_valid  = 1'b0;
        bus.start     = 1'b0;
        bus.manual_we = 1'b0;
        bus.sel       = 3'd0;
    endtask

    task automatic start_frame();
        bus.mode  = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", {31'd0, bus.busy}, 32'd1);
        chk("start_slot", {29'd0, bus.slot}, 32'd0);
    endtask

    task automatic send_bit(input logic b, input int idx);
        bus.serial_in = b;
        bus.in_valid  = 1'b1;
        bus.start     = 1'b0;
        tick();
        bus.in_valid  = 1'b0;
        if (idx < 6) begin
            chk("bit_slot", {29'd0, bus.slot}, idx + 1);
            chk("bit_busy", {31'd0, bus.busy}, 32'd1);
            chk("bit_fd", {31'd0, bus.frame_done}, 32'd0);
        end else begin
            chk("last_slot", {29'd0, bus.slot}, 32'd0);
            chk("last_busy", {31'd0, bus.busy}, 32'd0);
            chk("last_fd", {31'd0, bus.frame_done}, 32'd1);
        end
    endtask

    task automatic send_frame(input logic [6:0] f);
        for (int i = 0; i < 7; i++) send_bit(f[i], i);
    endtask

    task automatic manual_write(input logic [2:0] s, input logic b);
        bus.mode      = 1'b0;
        bus.sel       = s;
        bus.serial_in = b;
        bus.manual_we = 1'b1;
        tick();
        bus.manual_we = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        fd_count = 0;
        resetn   = 1'b0;
        bus.mode = 1'b0;
        idle_inputs();
        #23;
        chk("rst_q", {25'd0, bus.q}, 32'h00);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_slot", {29'd0, bus.slot}, 32'd0);
        chk("rst_fd", {31'd0, bus.frame_done}, 32'd0);
        resetn = 1'b1;
        tick();

        // Manual writes, including out-of-range select
        manual_write(3'd3, 1'b1);
        chk("man_s3", {25'd0, bus.q}, 32'h08);
        manual_write(3'd5, 1'b1);
        chk("man_s5", {25'd0, bus.q}, 32'h28);
        manual_write(3'd7, 1'b1);
        chk("man_s7", {25'd0, bus.q}, 32'h29);

        // Async reset mid-frame after 3 bits
        start_frame();
        send_bit(1'b1, 0);
        send_bit(1'b0, 1);
        send_bit(1'b1, 2);
        chk("pre_rst_q", {25'd0, bus.q}, 32'h29);
        resetn = 1'b0;
        #1;
        chk("arst_q", {25'd0, bus.q}, 32'h00);
        chk("arst_slot", {29'd0, bus.slot}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_fd", {31'd0, bus.frame_done}, 32'd0);
        #2;
        resetn = 1'b1;
        bus.mode = 1'b0;
        tick();
        fd_count = 0;

        // Auto frame 1,0,1,1,0,0,1 (slot 0 first)
        start_frame();
        for (int i = 0; i < 6; i++) begin
            send_bit(((7'b1001101 >> i) & 7'd1) != 7'd0, i);
            chk("frame_q_hold", {25'd0, bus.q}, 32'h00);
        end
        send_bit(1'b1, 6);
        chk("frame_q", {25'd0, bus.q}, 32'h4D);
        tick();
        chk("fd_one_cycle", {31'd0, bus.frame_done}, 32'd0);
        chk("frame_q_keep", {25'd0, bus.q}, 32'h4D);
        chk("fd_count1", fd_count, 32'd1);

        // Gaps and restart
        start_frame();
        send_bit(1'b0, 0);
        send_bit(1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gap_slot", {29'd0, bus.slot}, 32'd2);
            chk("gap_busy", {31'd0, bus.busy}, 32'd1);
        end
        send_bit(1'b0, 2);
        send_bit(1'b1, 3);
        send_bit(1'b0, 4);
        bus.serial_in = 1'b1;
        bus.in_valid  = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        chk("restart_slot", {29'd0, bus.slot}, 32'd0);
        chk("restart_busy", {31'd0, bus.busy}, 32'd1);
        chk("restart_q", {25'd0, bus.q}, 32'h4D);
        send_frame(7'h7F);
        chk("ones_q", {25'd0, bus.q}, 32'h7F);

        // Abort after 4 bits
        start_frame();
        send_bit(1'b0, 0);
        send_bit(1'b0, 1);
        send_bit(1'b0, 2);
        send_bit(1'b0, 3);
        bus.mode = 1'b0;
        tick();
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_slot", {29'd0, bus.slot}, 32'd0);
        chk("abort_q", {25'd0, bus.q}, 32'h7F);
        chk("abort_fd", {31'd0, bus.frame_done}, 32'd0);

        // manual_we ignored with mode=1 in IDLE and during COLLECT
        bus.mode      = 1'b1;
        bus.sel       = 3'd2;
        bus.serial_in = 1'b0;
        bus.manual_we = 1'b1;
        tick();
        chk("lock_idle_q", {25'd0, bus.q}, 32'h7F);
        bus.manual_we = 1'b0;
        start_frame();
        bus.manual_we = 1'b1;
        tick();
        bus.manual_we = 1'b0;
        chk("lock_coll_q", {25'd0, bus.q}, 32'h7F);
        bus.mode = 1'b0;
        tick();
        chk("fd_count2", fd_count, 32'd2);

        // Back-to-back frames 0x55 then 0x2A
        start_frame();
        send_frame(7'h55);
        chk("b2b_q1", {25'd0, bus.q}, 32'h55);
        start_frame();
        chk("b2b_fd_low", {31'd0, bus.frame_done}, 32'd0);
        send_frame(7'h2A);
        chk("b2b_q2", {25'd0, bus.q}, 32'h2A);
        tick();
        chk("fd_count4", fd_count, 32'd4);

        // Manual writes of both polarities after auto frames
        idle_inputs();
        manual_write(3'd0, 1'b1);
        chk("man_after_s0", {25'd0, bus.q}, 32'h2B);
        manual_write(3'd5, 1'b0);
        chk("man_clear_s5", {25'd0, bus.q}, 32'h0B);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/onetoseven_deframer.md
Name: onetoseven_deframer

Overview:
- Receive-side counterpart to the 7-to-1 switch selector. The selector picks one of seven bits by a 3-bit select; this block distributes a 1-bit serial stream back into a 7-bit parallel register.
- Two modes:
  - Manual: a single bit is written to an addressed slot.
  - Auto: a slot counter collects a full 7-bit frame, then updates the output atomically.
- Sits between the board switches/serial source and the LEDR display logic.

Parameters:
- SLOTS, 7, number of output slots; must satisfy 2**SEL_W >= SLOTS.
- SEL_W, 3, width of slot select and slot counter.

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous reset, active-low
- serial_in  input  1  data bit to be stored
- in_valid  input  1  auto mode: serial_in is valid this cycle
- mode  input  1  0 = manual, 1 = auto
- start  input  1  auto mode: begin or restart frame collection
- manual_we  input  1  manual mode: write serial_in to slot sel
- sel  input  SEL_W  manual-mode target slot
- q  output  SLOTS  registered parallel output
- slot  output  SEL_W  current auto-mode slot index (next bit position)
- busy  output  1  high while in state COLLECT
- frame_done  output  1  one-cycle pulse when a full frame is committed to q

Behaviour:
- Reset (resetn=0, async): q=0, slot=0, busy=0, frame_done=0, shadow=0, state=IDLE. Reset mid-frame discards the partial frame.
- States: IDLE, COLLECT. busy is 1 exactly when state=COLLECT.
- Manual writes (mode=0, state=IDLE, manual_we=1):
  - q[sel] <= serial_in at the next edge; other bits hold; latency 1 cycle.
  - sel >= SLOTS (sel=7) targets slot 0, mirroring the transmit-side default.
  - manual_we is ignored in COLLECT or when mode=1.
- Frame start:
  - IDLE, mode=1, start=1 -> COLLECT; slot <= 0; shadow <= 0.
  - A simultaneous in_valid bit is ignored.
- Collection (COLLECT, in_valid=1, start=0):
  - shadow[slot] <= serial_in; slot <= slot+1.
  - in_valid=0 leaves state and slot unchanged; gaps are allowed.
- Frame commit (COLLECT, in_valid=1, slot=SLOTS-1):
  - q <= shadow with bit SLOTS-1 = serial_in, so all 7 bits update in one edge.
  - frame_done=1 for the following cycle only; slot <= 0; state -> IDLE.
- Restart: start=1 in COLLECT restarts with slot <= 0 and shadow <= 0. A simultaneous in_valid bit is dropped. q is unchanged.
- Abort: mode=0 while in COLLECT -> IDLE, slot <= 0, q unchanged, no frame_done.
- q changes only on a manual write or a frame commit.
- frame_done is registered, never combinational.
- slot never exceeds SLOTS-1; it wraps to 0 on commit.

Decomposition:
- Shared package deframe_pkg:
  - state enum {IDLE, COLLECT};
  - constants SLOTS_DEF=7, SEL_W_DEF=3;
  - function sel_clamp(sel) returning 0 for sel >= SLOTS.
- One natural sub-module, slot_counter: SEL_W-bit counter with clear, enable, and a terminal flag at SLOTS-1.
- Top level holds the FSM, shadow register and q.

Test Plan:
1. Reset: hold resetn=0 mid-COLLECT after 3 bits -> q=0000000, slot=0, busy=0, frame_done=0 immediately (asynchronous).
2. Manual writes: mode=0, write serial_in=1 to sel=3, then to sel=5 -> q=0101000. Then sel=7 with serial_in=1 -> q=0101001.
3. Auto frame: start, then 7 valid bits 1,0,1,1,0,0,1 (slot 0 first) -> q=1001101 one cycle after the 7th bit; frame_done high for exactly one cycle; busy falls the same edge.
4. Gaps and restart:
   - Deassert in_valid for 4 cycles mid-frame -> slot holds.
   - Assert start after 5 bits -> slot=0.
   - Then 7 bits all 1 -> q=1111111; the earlier partial data is absent.
5. Abort and lockout:
   - Collect 4 bits, drop mode to 0 -> IDLE, q keeps its previous value, no frame_done.
   - manual_we during COLLECT -> q unchanged.
6. Back-to-back frames: start on the cycle after frame_done, then send frames 0x55 and 0x2A (7-bit) -> two frame_done pulses; q matches each frame in turn.
